// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the ADAU1761 configuration sequencer: script entry
// layout, device address and the sequencer state encoding.
package codec_cfg_pkg;

    localparam logic [6:0] ADAU1761_DEV_ADDR = 7'h3B;

    localparam int ENTRY_W   = 25;
    localparam int DELAY_BIT = 24;
    localparam int ADDR_MSB  = 23;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_MSB  = 7;
    localparam int DATA_LSB  = 0;

    localparam logic [ENTRY_W-1:0] DELAY_ENTRY = {1'b1, 24'h000000};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic [ENTRY_W-1:0] wr_entry(input logic [15:0] reg_addr,
                                                    input logic [7:0]  data);
        return {1'b0, reg_addr, data};
    endfunction

endpackage

// File: rtl/codec_config_rom.sv
// Synchronous-read ROM holding the ADAU1761 bring-up script.
// Addresses at or beyond NUM_ENTRIES read back as zero.
module codec_config_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 24
) (
    input  logic               clk,
    input  logic [7:0]         addr,
    output logic [ENTRY_W-1:0] entry
);

    // Clocking and PLL first; the PLL must lock before the core is touched.
    function automatic logic [ENTRY_W-1:0] script_word(input logic [7:0] a);
        case (a)
            8'd0:    return wr_entry(16'h4000, 8'h0E);
            8'd1:    return wr_entry(16'h4002, 8'h01);
            8'd2:    return DELAY_ENTRY;
            8'd3:    return wr_entry(16'h4015, 8'h01);
            8'd4:    return wr_entry(16'h4016, 8'h00);
            8'd5:    return wr_entry(16'h4017, 8'h00);
            8'd6:    return wr_entry(16'h4019, 8'h13);
            8'd7:    return wr_entry(16'h401C, 8'h21);
            8'd8:    return wr_entry(16'h401E, 8'h41);
            8'd9:    return wr_entry(16'h4020, 8'h03);
            8'd10:   return wr_entry(16'h4021, 8'h09);
            8'd11:   return wr_entry(16'h4022, 8'h01);
            8'd12:   return wr_entry(16'h4023, 8'hE7);
            8'd13:   return wr_entry(16'h4024, 8'hE7);
            8'd14:   return wr_entry(16'h4025, 8'hE7);
            8'd15:   return wr_entry(16'h4026, 8'hE7);
            8'd16:   return wr_entry(16'h4029, 8'h03);
            8'd17:   return wr_entry(16'h402A, 8'h03);
            8'd18:   return wr_entry(16'h40F2, 8'h01);
            8'd19:   return wr_entry(16'h40F3, 8'h01);
            8'd20:   return wr_entry(16'h40F9, 8'h7F);
            8'd21:   return wr_entry(16'h40FA, 8'h03);
            8'd22:   return wr_entry(16'h400A, 8'h01);
            8'd23:   return wr_entry(16'h400C, 8'h01);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (int'(addr) < NUM_ENTRIES) entry <= script_word(addr);
        else                          entry <= '0;
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec register script, issuing one I2C write at a time with
// timeout/NACK retry and timed delay entries; reports busy/done/error.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES    = 24,
    parameter int DELAY_CYCLES   = 1000000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MAX_RETRIES    = 3,
    parameter int AUTO_START     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_valid,
    input  logic        i2c_ready,
    output logic [15:0] i2c_reg_addr,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        config_done,
    output logic        error,
    output logic [7:0]  entry_idx,
    output logic [2:0]  state_dbg
);

    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_ENTRIES - 1);

    state_t             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               auto_pend_q;
    logic               advance;
    logic [ENTRY_W-1:0] rom_entry;

    // The ROM is addressed with the next index so its output is valid in FETCH.
    codec_config_rom #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_rom (
        .clk  (clk),
        .addr (idx_d),
        .entry(rom_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rty_q       <= '0;
            to_q        <= '0;
            dly_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            auto_pend_q <= (AUTO_START != 0);
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rty_q       <= rty_d;
            to_q        <= to_d;
            dly_q       <= dly_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            auto_pend_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rty_d   = rty_q;
        to_d    = to_q;
        dly_d   = dly_q;
        addr_d  = addr_q;
        data_d  = data_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_pend_q) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    rty_d   = '0;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    rty_d   = '0;
                end
            end
            ST_FETCH: begin
                if (rom_entry[DELAY_BIT]) begin
                    state_d = ST_DELAY;
                    dly_d   = DLY_LOAD;
                end else begin
                    state_d = ST_ISSUE;
                    addr_d  = rom_entry[ADDR_MSB:ADDR_LSB];
                    data_d  = rom_entry[DATA_MSB:DATA_LSB];
                end
            end
            // Request handshake: i2c_valid is held with stable address/data until
            // a cycle where i2c_ready is also high; that cycle is the transfer.
            ST_ISSUE: begin
                if (i2c_ready) begin
                    state_d = ST_WAIT_DONE;
                    to_d    = '0;
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_done && !i2c_nack) begin
                    advance = 1'b1;
                end else if (i2c_done || (to_q == TO_LAST)) begin
                    if (rty_q < RTY_MAX) begin
                        rty_d   = rty_q + RTY_W'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) advance = 1'b1;
                else             dly_d   = dly_q - DLY_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 8'd1;
                rty_d   = '0;
                state_d = ST_FETCH;
            end
        end
    end

    assign i2c_valid    = (state_q == ST_ISSUE);
    assign i2c_reg_addr = addr_q;
    assign i2c_wdata    = data_q;
    assign config_done  = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign entry_idx    = idx_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: randomized engine responses, a script-level
// reference model feeding an expected queue, and a decoupled monitor.
module tb_codec_config_sequencer;

    localparam int NUM_ENTRIES    = 6;
    localparam int DELAY_CYCLES   = 10;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int MAX_RETRIES    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        i2c_ready = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_valid, busy, config_done, error;
    logic [15:0] i2c_reg_addr;
    logic [7:0]  i2c_wdata, entry_idx;
    logic [2:0]  state_dbg;

    codec_config_sequencer #(
        .NUM_ENTRIES   (NUM_ENTRIES),
        .DELAY_CYCLES  (DELAY_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .AUTO_START    (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .i2c_valid   (i2c_valid),
        .i2c_ready   (i2c_ready),
        .i2c_reg_addr(i2c_reg_addr),
        .i2c_wdata   (i2c_wdata),
        .i2c_done    (i2c_done),
        .i2c_nack    (i2c_nack),
        .busy        (busy),
        .config_done (config_done),
        .error       (error),
        .entry_idx   (entry_idx),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    typedef struct {
        int kind;   // 0: unchecked, 1: cycles since last done, 2: cycles since last accept
        int val;
    } gap_t;

    logic [23:0] exp_q[$];
    gap_t        gap_q[$];
    int          total = 0;
    int          bad = 0;
    int          fail_plan[NUM_ENTRIES];
    int          att[NUM_ENTRIES];
    bit          fail_silent = 1'b0;
    int          ready_mode = 0;
    bit          force_done = 1'b0;
    bit          exp_err;
    int          exp_idx;

    // Expected script contents (first NUM_ENTRIES entries of the codec script).
    function automatic logic [24:0] script(input int i);
        case (i)
            0:       return {1'b0, 16'h4000, 8'h0E};
            1:       return {1'b0, 16'h4002, 8'h01};
            2:       return {1'b1, 24'h000000};
            3:       return {1'b0, 16'h4015, 8'h01};
            4:       return {1'b0, 16'h4016, 8'h00};
            5:       return {1'b0, 16'h4017, 8'h00};
            default: return '0;
        endcase
    endfunction

    function automatic int lookup(input logic [15:0] a);
        logic [24:0] w;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w = script(i);
            if (!w[24] && w[23:8] == a) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walks the script with the planned failures per entry and
    // queues every expected write attempt plus its expected issue timing.
    task automatic run_model();
        int add;
        bit have_prev;
        logic [24:0] ent;
        gap_t g;
        add = 0;
        have_prev = 1'b0;
        exp_err = 1'b0;
        exp_idx = NUM_ENTRIES - 1;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            ent = script(e);
            if (ent[24]) begin
                add += 1 + DELAY_CYCLES;
                continue;
            end
            for (int a = 0; a <= MAX_RETRIES; a++) begin
                if (a == 0) begin
                    g.kind = have_prev ? 1 : 0;
                    g.val  = 2 + add;
                end else if (fail_silent) begin
                    g.kind = 2;
                    g.val  = 1 + TIMEOUT_CYCLES;
                end else begin
                    g.kind = 1;
                    g.val  = 1;
                end
                exp_q.push_back(ent[23:0]);
                gap_q.push_back(g);
                if (a >= fail_plan[e]) break;
            end
            if (fail_plan[e] > MAX_RETRIES) begin
                exp_err = 1'b1;
                exp_idx = e;
                return;
            end
            have_prev = 1'b1;
            add = 0;
        end
    endtask

    // ---------------- engine driver ----------------
    int done_cnt = 0;
    bit pend_nack = 1'b0;
    int eng_idx;

    initial begin
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (force_done) begin
                i2c_done   = 1'b1;
                force_done = 1'b0;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = pend_nack;
                end
            end
            case (ready_mode)
                0:       i2c_ready = 1'b1;
                1:       i2c_ready = ($urandom_range(0, 3) != 0);
                default: i2c_ready = 1'b0;
            endcase
            if (i2c_valid && i2c_ready) begin
                eng_idx = lookup(i2c_reg_addr);
                if (eng_idx >= 0) begin
                    att[eng_idx]++;
                    if (att[eng_idx] <= fail_plan[eng_idx]) begin
                        if (!fail_silent) begin
                            done_cnt  = $urandom_range(1, 6);
                            pend_nack = 1'b1;
                        end
                    end else begin
                        done_cnt  = $urandom_range(1, 6);
                        pend_nack = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          cyc_done = 0;
    int          cyc_acc = 0;
    logic        prev_valid = 1'b0;
    logic [23:0] lat = '0;
    gap_t        mg;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc_done++;
            cyc_acc++;
            if (i2c_valid && !prev_valid) begin
                check("valid_rise_expected", (gap_q.size() != 0), 1);
                if (gap_q.size() != 0) begin
                    mg = gap_q.pop_front();
                    if (mg.kind == 1) check("issue_gap_from_done", cyc_done, mg.val);
                    else if (mg.kind == 2) check("issue_gap_from_accept", cyc_acc, mg.val);
                end
                lat = {i2c_reg_addr, i2c_wdata};
            end else if (i2c_valid && prev_valid) begin
                check("held_addr_data_stable", {i2c_reg_addr, i2c_wdata}, lat);
            end
            if (i2c_valid && i2c_ready) begin
                check("transfer_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("transfer_addr_data", {i2c_reg_addr, i2c_wdata}, exp_q.pop_front());
                cyc_acc = 0;
            end
            if (i2c_done) cyc_done = 0;
            prev_valid = i2c_valid;
        end
    end

    // ---------------- helper tasks ----------------
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (!busy) break;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic final_check(input string tag);
        check({tag, "_config_done"}, config_done, !exp_err);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_entry_idx"}, entry_idx, exp_idx);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            fail_plan[i] = 0;
            att[i] = 0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int sz;

    initial begin
        clear_plan();
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", i2c_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_config_done", config_done, 0);
        check("reset_error", error, 0);
        check("reset_entry_idx", entry_idx, 0);
        check("reset_reg_addr", i2c_reg_addr, 0);
        check("reset_wdata", i2c_wdata, 0);

        // Auto-start, clean run with random ready, delay entry in the script.
        ready_mode = 1;
        run_model();
        @(negedge clk);
        reset = 1'b1;
        wait_idle(1000);
        final_check("auto_run");

        // Stray done in DONE changes nothing.
        force_done = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("stray_done_config_done", config_done, 1);
        check("stray_done_busy", busy, 0);
        check("stray_done_valid", i2c_valid, 0);

        // Stalled ready, two NACKs on entry 3, start ignored while busy.
        clear_plan();
        fail_plan[3] = 2;
        ready_mode = 2;
        run_model();
        start_pulse();
        repeat (50) @(negedge clk);
        #3;
        check("stall_valid_held", i2c_valid, 1);
        check("stall_entry_idx", entry_idx, 0);
        ready_mode = 0;
        repeat (5) @(negedge clk);
        start_pulse();
        wait_idle(1000);
        final_check("nack_retry_run");

        // Entry 3 NACKed beyond its retries.
        clear_plan();
        fail_plan[3] = MAX_RETRIES + 1;
        ready_mode = 1;
        run_model();
        start_pulse();
        wait_idle(1000);
        final_check("error_run");
        force_done = 1'b1;
        repeat (30) @(negedge clk);
        #3;
        check("error_sticky", error, 1);
        check("error_idx_frozen", entry_idx, 3);
        check("error_no_valid", i2c_valid, 0);

        // Rerun after error; entry 1 silently times out once.
        clear_plan();
        fail_plan[1] = 1;
        fail_silent = 1'b1;
        ready_mode = 0;
        run_model();
        start_pulse();
        #3;
        check("rerun_error_cleared", error, 0);
        check("rerun_busy", busy, 1);
        check("rerun_entry_idx", entry_idx, 0);
        wait_idle(1000);
        final_check("timeout_retry_run");

        // Async reset while waiting for entry 1 completion.
        clear_plan();
        fail_silent = 1'b0;
        run_model();
        sz = exp_q.size();
        start_pulse();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() <= sz - 2) break;
        end
        check("second_write_accepted", (exp_q.size() <= sz - 2), 1);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_valid", i2c_valid, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_entry_idx", entry_idx, 0);
        exp_q.delete();
        gap_q.delete();
        clear_plan();
        repeat (10) @(negedge clk);
        #3;
        check("reset_hold_busy", busy, 0);
        check("reset_hold_valid", i2c_valid, 0);
        run_model();
        @(negedge clk);
        reset = 1'b1;
        wait_idle(1000);
        final_check("post_reset_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Power-up and re-configuration controller for the ADAU1761 codec's I2C control port.
- Walks a register-write script held in a ROM and issues one write at a time to the I2C byte-engine through a valid/ready request plus done/nack completion handshake.
- Inserts timed delays where the script requires them (PLL lock) and retries NACKed writes.
- Reports busy/done/error to the top level, which gates audio streaming until configuration completes.

Parameters:
- NUM_ENTRIES, 24, number of script entries in the ROM (1..255).
- DELAY_CYCLES, 1000000, clk cycles per script delay entry (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 200000, maximum cycles from accepted request to i2c_done before the attempt counts as failed.
- MAX_RETRIES, 3, retries per entry after the first failed attempt.
- AUTO_START, 1, when 1, the script runs once automatically after reset deassertion.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; reruns the script from entry 0. Ignored while busy.
- i2c_valid  out  1  write request valid; held until accepted.
- i2c_ready  in  1  I2C engine can accept a request.
- i2c_reg_addr  out  16  codec register address; stable while i2c_valid=1.
- i2c_wdata  out  8  register data; stable while i2c_valid=1.
- i2c_done  in  1  single-cycle pulse: the current transaction finished.
- i2c_nack  in  1  qualifies i2c_done: the transaction was NACKed.
- busy  out  1  script in progress.
- config_done  out  1  script completed without error; sticky until the next start.
- error  out  1  entry exhausted its retries; sticky until the next start.
- entry_idx  out  8  index of the current or failing entry.

Behaviour:
- Reset (reset=0, async): FSM=IDLE. All outputs 0; i2c_reg_addr and i2c_wdata are 0.
- ROM entry format, 25 bits: [24]=is_delay, [23:8]=reg_addr, [7:0]=data.
  - Delay entries ignore the address and data fields.
- FSM states: IDLE, FETCH, ISSUE, WAIT_DONE, DELAY, DONE, ERROR.
- IDLE:
  - Goes to FETCH on a start pulse.
  - Also goes to FETCH on the first cycle after reset release when AUTO_START=1.
  - On leaving IDLE: entry_idx=0, retry count=0, config_done=0, error=0.
- FETCH (1 cycle): the ROM is read synchronously; the fields are registered.
  - Delay entry: go to DELAY and load the delay counter with DELAY_CYCLES-1.
  - Write entry: go to ISSUE.
- ISSUE: i2c_valid=1 with the registered address and data.
  - The transfer occurs in the cycle where i2c_valid & i2c_ready are both 1.
  - After the transfer, i2c_valid drops the next cycle and the FSM goes to WAIT_DONE with the timeout counter cleared.
- WAIT_DONE:
  - i2c_done & !i2c_nack: the entry succeeded; go to NEXT-handling.
  - i2c_done & i2c_nack, or the timeout counter reaching TIMEOUT_CYCLES-1: the attempt failed.
    - If retry count < MAX_RETRIES: increment it and return to ISSUE.
    - Otherwise go to ERROR.
  - i2c_done arriving on the same cycle as the timeout terminal count: done wins.
- DELAY: count down to 0, then NEXT-handling.
- NEXT-handling (combinational, no extra cycle):
  - If entry_idx = NUM_ENTRIES-1: go to DONE.
  - Otherwise: entry_idx+1, retry count=0, go to FETCH.
- Per-entry latency: write = 1 (FETCH) + handshake + engine time. Delay = 1 + DELAY_CYCLES.
- DONE: config_done=1, busy=0. A start pulse reruns the script (clears config_done).
- ERROR: error=1, busy=0, entry_idx frozen at the failing entry. A start pulse reruns the script.
- busy=1 in every state except IDLE, DONE and ERROR.
- start pulses received while busy are dropped; they are not queued.
- Async reset mid-transaction:
  - i2c_valid drops immediately.
  - An i2c_done arriving afterwards in IDLE/DONE/ERROR is ignored.
- Counter widths: $clog2 of the respective parameter, minimum 1. The retry counter saturates at MAX_RETRIES.

Decomposition:
- Package codec_cfg_pkg holds:
  - ADAU1761 7-bit device address 7'h3B.
  - Entry field positions and widths (ENTRY_W=25, DELAY_BIT=24).
  - The FSM state enum.
- Sub-module codec_config_rom: synchronous-read ROM, parameter NUM_ENTRIES.
  - Ports: clk, addr[7:0] in, entry[24:0] out.
  - Holds the team's ADAU1761 script: clock control, PLL setup, PLL lock delay, then the serial-port, mixer and DAC/headphone registers.

Test Plan:
- Auto-start, ready tied 1, done with nack=0 4 cycles after each accept (NUM_ENTRIES=4, no delays) -> exactly 4 accepted transfers with the ROM's addr/data in order; config_done=1 and busy=0 after the 4th done; error=0.
- Delay entry at index 1, DELAY_CYCLES=10 -> 11 cycles between leaving entry 0 and FETCH of entry 2; i2c_valid stays 0 throughout.
- Engine NACKs entry 2 twice, then ACKs (MAX_RETRIES=3) -> entry 2 issued 3 times with identical addr/data; the script completes with config_done=1.
- Engine NACKs entry 2 four times -> error=1, entry_idx=2, busy=0, no further i2c_valid. A subsequent start pulse -> error=0 and the rerun begins at entry 0.
- i2c_ready held 0 for 50 cycles -> i2c_valid stays 1 with stable addr/data; no timeout counted. Never assert i2c_done (TIMEOUT_CYCLES=20) -> retry issued after 20 cycles.
- reset=0 during WAIT_DONE -> i2c_valid, busy and entry_idx are 0 immediately. A stray i2c_done afterwards (AUTO_START=0) -> no state change. start is ignored while busy.
